// File: rtl/uart_rx.sv
// 8-bit UART receiver with 16x oversampling and mid-bit sampling.
// Define UART_RX_PARITY_EN to expect an even-parity bit between the data and stop bits.
module uart_rx #(
    parameter int OVS_DIV = 326
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] data_out,
    output logic       data_valid,
    output logic       framing_err,
    output logic       parity_err,
    output logic       busy
);
    localparam int CW = (OVS_DIV > 1) ? $clog2(OVS_DIV) : 1;

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
    logic          par_smp;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t        state;
    logic          rx_m, rx_s, rx_p;
    logic [CW-1:0] tick_cnt;
    logic [3:0]    smp_cnt;
    logic [2:0]    bit_cnt;
    logic [7:0]    shreg;
    logic          stop_smp;
    logic          stop_done;
    logic          tick;
    logic          start_edge;
    logic          bit_end;

    assign tick       = (tick_cnt == CW'(OVS_DIV - 1));
    assign start_edge = (state == IDLE) && rx_p && !rx_s;
    assign bit_end    = tick && (smp_cnt == 4'd15);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            rx_m        <= 1'b1;
            rx_s        <= 1'b1;
            rx_p        <= 1'b1;
            tick_cnt    <= '0;
            smp_cnt     <= '0;
            bit_cnt     <= '0;
            shreg       <= '0;
            stop_smp    <= 1'b0;
            stop_done   <= 1'b0;
            data_out    <= '0;
            data_valid  <= 1'b0;
            framing_err <= 1'b0;
            busy        <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_smp     <= 1'b0;
            parity_err  <= 1'b0;
`endif
        end else begin
            rx_m        <= rx;
            rx_s        <= rx_m;
            rx_p        <= rx_s;
            data_valid  <= 1'b0;
            framing_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err  <= 1'b0;
`endif
            // Restarting the divider on the start edge aligns every later sample to mid-bit
            if (start_edge || tick)
                tick_cnt <= '0;
            else
                tick_cnt <= tick_cnt + CW'(1);
            if (tick)
                smp_cnt <= smp_cnt + 4'd1;

            case (state)
                IDLE: begin
                    if (start_edge) begin
                        state   <= START;
                        busy    <= 1'b1;
                        smp_cnt <= '0;
                    end
                end
                START: begin
                    if (tick && smp_cnt == 4'd7) begin
                        smp_cnt <= '0;
                        if (rx_s) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end else begin
                            state   <= DATA;
                            bit_cnt <= '0;
                        end
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        shreg   <= {rx_s, shreg[7:1]};
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                            state <= PARITY;
`else
                            state <= STOP;
`endif
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (bit_end) begin
                        par_smp <= rx_s;
                        state   <= STOP;
                    end
                end
`endif
                STOP: begin
                    // Sample first, publish one clock later
                    if (stop_done) begin
                        stop_done   <= 1'b0;
                        data_out    <= shreg;
                        data_valid  <= 1'b1;
                        framing_err <= ~stop_smp;
`ifdef UART_RX_PARITY_EN
                        parity_err  <= par_smp ^ (^shreg);
`endif
                        state       <= IDLE;
                        busy        <= 1'b0;
                    end else if (bit_end) begin
                        stop_smp  <= rx_s;
                        stop_done <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

`ifndef UART_RX_PARITY_EN
    assign parity_err = 1'b0;
`endif

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter OVS_DIV, default 326, meaning clk cycles per oversample tick (16 ticks per bit; 326 gives ~9600 baud at 50 MHz).
REQ-002 SHALL have port clk  input  1  system clock; all logic on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port rx  input  1  asynchronous serial line, idle high.
REQ-005 SHALL have port data_out  output  8  last received byte.
REQ-006 SHALL have port data_valid  output  1  one-cycle pulse when data_out updates.
REQ-007 SHALL have port framing_err  output  1  stop bit sampled low; valid only with data_valid.
REQ-008 SHALL have port parity_err  output  1  parity mismatch; valid only with data_valid.
REQ-009 SHALL have port busy  output  1  high whenever state is not IDLE.

Function
REQ-010 SHALL pass rx through a 2-flop synchronizer (rx_s) plus a previous-value flop (rx_p); rx has no other use.
REQ-011 SHALL run a tick counter 0..OVS_DIV-1 that pulses tick when it reaches OVS_DIV-1, then wraps to 0.
REQ-012 SHALL clear the tick and sample counters on start-edge detect so sampling is phase-aligned to the start edge.
REQ-013 SHALL implement states IDLE, START, DATA, PARITY, STOP.
REQ-014 SHALL leave IDLE for START only on falling edge (rx_p=1, rx_s=0); a line held low never retriggers.
REQ-015 SHALL in START sample rx_s on the 8th tick (mid-bit); if 1, return to IDLE with no output (glitch reject); if 0, go to DATA.
REQ-016 SHALL in DATA sample rx_s every 16th tick, shifting each bit in LSB first; after the 8th bit go to PARITY when the parity feature is compiled in, otherwise STOP.
REQ-017 SHALL in PARITY sample the bit after 16 ticks and compare it against even parity of the 8 data bits.
REQ-018 SHALL in STOP sample after 16 ticks, then on the next clk load data_out, pulse data_valid for exactly 1 cycle, set framing_err=~stop_sample, set parity_err, and go to IDLE.
REQ-019 SHALL update data_out and pulse data_valid even when framing_err or parity_err is set.
REQ-020 SHALL hold framing_err and parity_err at 0 in every cycle where data_valid=0.
REQ-021 SHALL hold data_out stable between data_valid pulses.
REQ-022 SHALL accept a new start edge in the first IDLE cycle, so back-to-back frames with one stop bit are received without loss.

Reset
REQ-023 SHALL on rst_n=0 at a clk edge set state=IDLE, all counters and the shift register to 0, synchronizer flops and rx_p to 1, data_out=0x00, and data_valid=framing_err=parity_err=busy=0.
REQ-024 SHALL discard any partial frame on reset mid-frame, with no data_valid generated for it.
REQ-025 SHALL detect rx held low at reset release as a falling edge once it reaches rx_s.

Configuration
REQ-026 SHALL, when UART_RX_PARITY_EN is defined, include the PARITY state and expect frames of start, 8 data, even parity, stop (11 bits).
REQ-027 SHALL, when UART_RX_PARITY_EN is undefined, omit the PARITY state and parity logic, expect 10-bit frames, and tie parity_err to 0.

Verification (bench uses OVS_DIV=4, so one bit = 64 clk)
REQ-028 SHALL cover: frame 0x55, stop=1 -> data_out=0x55, data_valid one cycle, framing_err=0, busy low after.
REQ-029 SHALL cover: rx low for 12 clk then high -> no data_valid, busy returns to 0 within 40 clk.
REQ-030 SHALL cover: frame 0xA3 with stop=0, line held low 200 clk then high -> data_out=0xA3, framing_err=1, no further data_valid until the next genuine falling edge.
REQ-031 SHALL cover: rst_n=0 for 1 cycle during bit 4 of 0x3C, then frame 0x0F -> no output for 0x3C, data_out=0x0F, flags 0.
REQ-032 SHALL cover: back-to-back frames 0x00 then 0xFF -> two data_valid pulses 640 clk apart (704 with parity), values in order.
REQ-033 SHALL cover, with UART_RX_PARITY_EN: 0x07 with parity bit 0 -> parity_err=1; 0x07 with parity bit 1 -> parity_err=0.
